// File: rtl/regfile_onehot_wr_pkg.sv
// Shared widths for the write-register decoder and the register file it feeds.
package regfile_onehot_wr_pkg;

    localparam int unsigned REGNUM  = 32;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned KEY_LEN = 5;
    localparam int unsigned CNT_W   = 16;

    typedef logic [WIDTH-1:0]   data_t;
    typedef logic [KEY_LEN-1:0] key_t;
    typedef logic [REGNUM-1:0]  onehot_t;

endpackage

// File: rtl/regfile_onehot_wr_onehot_check.sv
// Combinational one-hot validator and OR-reduction index encoder.
module onehot_check
    import regfile_onehot_wr_pkg::*;
(
    input  logic [REGNUM-1:0]  i_vec,
    output logic               o_is_onehot,
    output logic [KEY_LEN-1:0] o_idx
);

    logic [REGNUM-1:0] w_low_cleared;

    // A vector is one-hot when non-zero and clearing its lowest set bit leaves nothing.
    assign w_low_cleared = i_vec & (i_vec - REGNUM'(1));
    assign o_is_onehot   = (i_vec != '0) && (w_low_cleared == '0);

    // Index bit b is the OR of every vector bit whose position has bit b set.
    always_comb begin
        o_idx = '0;
        for (int b = 0; b < KEY_LEN; b++) begin
            for (int i = 0; i < REGNUM; i++) begin
                if (((i >> b) & 1) == 1) begin
                    o_idx[b] = o_idx[b] | i_vec[i];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// Register file written through a one-hot enable vector; two execute read
// ports with optional write bypass, one debug port, sticky malformed-vector flag.
module regfile_onehot_wr
    import regfile_onehot_wr_pkg::*;
#(
    parameter int unsigned BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [REGNUM-1:0]  wr_onehot,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [KEY_LEN-1:0] raddr1,
    input  logic [KEY_LEN-1:0] raddr2,
    output logic [WIDTH-1:0]   rdata1,
    output logic [WIDTH-1:0]   rdata2,
    input  logic [KEY_LEN-1:0] dbg_addr,
    output logic [WIDTH-1:0]   dbg_data,
    output logic               onehot_err,
    output logic [CNT_W-1:0]   wr_count
);

    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [WIDTH-1:0]   r_regs [REGNUM];
    logic               r_onehot_err;
    logic [CNT_W-1:0]   r_wr_count;

    logic               w_is_onehot;
    logic [KEY_LEN-1:0] w_idx;
    logic               w_commit;
    logic               w_illegal;
    logic               w_hit1;
    logic               w_hit2;

    onehot_check u_onehot_check (
        .i_vec       (wr_onehot),
        .o_is_onehot (w_is_onehot),
        .o_idx       (w_idx)
    );

    assign w_commit  = wen & w_is_onehot;
    assign w_illegal = wen & ~w_is_onehot;

    // Storage; register 0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGNUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && (w_idx != '0)) begin
            r_regs[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot_err <= 1'b0;
            r_wr_count   <= '0;
        end else begin
            if (w_illegal) begin
                r_onehot_err <= 1'b1;
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    // Forward only committed writes to non-zero addresses.
    assign w_hit1 = BYPASS_EN && w_commit && (w_idx == raddr1);
    assign w_hit2 = BYPASS_EN && w_commit && (w_idx == raddr2);

    assign rdata1     = (raddr1 == '0) ? '0 : (w_hit1 ? wdata : r_regs[raddr1]);
    assign rdata2     = (raddr2 == '0) ? '0 : (w_hit2 ? wdata : r_regs[raddr2]);
    assign dbg_data   = r_regs[dbg_addr];
    assign onehot_err = r_onehot_err;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr: bypass and non-bypass instances driven in lockstep
// and compared against an array-based reference model.
module tb_regfile_onehot_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [31:0] wr_onehot;
    logic [31:0] wdata;
    logic [4:0]  raddr1, raddr2, dbg_addr;

    logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
    logic        err_b, err_n;
    logic [15:0] cnt_b, cnt_n;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic        m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    regfile_onehot_wr #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wen(wen), .wr_onehot(wr_onehot), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b), .onehot_err(err_b), .wr_count(cnt_b)
    );

    regfile_onehot_wr #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .wr_onehot(wr_onehot), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n), .onehot_err(err_n), .wr_count(cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_err = 1'b0;
        m_cnt = 16'h0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp, input bit legal,
                                             input int idx, input logic [31:0] d);
        if (a == 5'd0) return 32'h0;
        if (byp && legal && idx == int'(a)) return d;
        return m_regs[a];
    endfunction

    // Apply the write rules to the model at the clock edge.
    task automatic model_edge(input logic w, input bit legal, input int idx, input logic [31:0] d);
        if (w) begin
            if (legal) begin
                m_cnt = m_cnt + 16'd1;
                if (idx != 0) m_regs[idx] = d;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic decode(input logic [31:0] oh, output bit legal, output int idx);
        legal = ($countones(oh) == 1);
        idx = 0;
        for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
    endtask

    // One checked cycle: drive, check combinational reads, clock, check registered state.
    task automatic step(input logic w, input logic [31:0] oh, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        bit legal;
        int idx;
        @(negedge clk);
        wen = w; wr_onehot = oh; wdata = d; raddr1 = a1; raddr2 = a2; dbg_addr = da;
        decode(oh, legal, idx);
        legal = legal && w;
        #1;
        check("rdata1_byp", rd1_b, exp_read(a1, 1'b1, legal, idx, d));
        check("rdata2_byp", rd2_b, exp_read(a2, 1'b1, legal, idx, d));
        check("rdata1_nobyp", rd1_n, exp_read(a1, 1'b0, legal, idx, d));
        check("rdata2_nobyp", rd2_n, exp_read(a2, 1'b0, legal, idx, d));
        check("dbg_byp", dbg_b, m_regs[da]);
        check("dbg_nobyp", dbg_n, m_regs[da]);
        @(posedge clk);
        model_edge(w, legal, idx, d);
        #1;
        check("onehot_err", 32'(err_b), 32'(m_err));
        check("onehot_err_nb", 32'(err_n), 32'(m_err));
        check("wr_count", 32'(cnt_b), 32'(m_cnt));
        check("wr_count_nb", 32'(cnt_n), 32'(m_cnt));
    endtask

    // Unchecked legal write used to push the counter around its range quickly.
    task automatic fast_write(input int r, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; wr_onehot = 32'h1 << r; wdata = d;
        @(posedge clk);
        model_edge(1'b1, 1'b1, r, d);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; wr_onehot = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Everything reads zero after reset.
        for (int a = 0; a < 32; a++) step(1'b0, 32'h0, 32'h0, 5'(a), 5'(31 - a), 5'(a));

        // Single write with bypass, then debug readback.
        step(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        step(1'b0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd5);

        // Register 0 accepts the write but stays zero.
        step(1'b1, 32'h0000_0001, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Sweep registers 1..31 then read back on both ports.
        for (int i = 1; i < 32; i++) step(1'b1, 32'h1 << i, 32'(100 + i), 5'(i), 5'(32 - i), 5'(i));
        for (int i = 1; i < 32; i++) step(1'b0, 32'h0, 32'h0, 5'(i), 5'(32 - i), 5'(i));

        // Malformed vectors: two bits, zero, and a malformed vector with wen low.
        step(1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd1);
        step(1'b0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd2);
        step(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd0);
        step(1'b0, 32'h0000_0003, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd1);

        // Randomized mix of legal, malformed and idle cycles.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] oh;
            logic [4:0]  a1;
            if ($urandom_range(0, 3) == 0) oh = $urandom;
            else oh = 32'h1 << $urandom_range(0, 31);
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($clog2(oh));
            step(1'($urandom_range(0, 1)), oh, $urandom, a1, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        // Reset asserted together with a legal write: the write is lost.
        @(negedge clk);
        wen = 1'b1; wr_onehot = 32'h0000_0080; wdata = 32'hA5A5_A5A5; dbg_addr = 5'd7; rst = 1'b1;
        model_clear();
        #1;
        check("async_clear_dbg", dbg_b, 32'h0);
        check("async_clear_err", 32'(err_b), 32'h0);
        @(negedge clk);
        rst = 1'b0; wen = 1'b0;
        step(1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);

        // Counter wrap: 65535 writes reach FFFF, one more returns to zero.
        for (int k = 0; k < 65534; k++) fast_write(k % 32, $urandom);
        step(1'b1, 32'h0000_0001, 32'h0, 5'd0, 5'd0, 5'd0);
        check("count_ffff", 32'(cnt_b), 32'h0000_FFFF);
        step(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 5'd8, 5'd8, 5'd8);
        check("count_wrap", 32'(cnt_b), 32'h0);
        step(1'b0, 32'h0, 32'h0, 5'd8, 5'd1, 5'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
